// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: MIPS funct opcodes, sequencer states
// and the channel map of the button synchroniser.
package alu_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] OP_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] OP_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] OP_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] OP_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] OP_XOR = 6'b100110;
    localparam logic [FUNCT_W-1:0] OP_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] OP_SRL = 6'b000010;
    localparam logic [FUNCT_W-1:0] OP_SRA = 6'b000011;

    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'd0,
        ST_WAIT_B  = 2'd1,
        ST_WAIT_OP = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    // Synchroniser channels: three load buttons, step button, mode switch.
    localparam int unsigned N_CH    = 5;
    localparam int unsigned CH_STEP = 3;
    localparam int unsigned CH_MODE = 4;

endpackage

// File: rtl/btn_edge_sync.sv
// Multi-channel synchroniser with edge history; emits one-cycle rise and fall
// pulses for each synchronised channel.
module btn_edge_sync #(
    parameter int unsigned N           = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_sync,
    output logic [N-1:0] o_rise_c,
    output logic [N-1:0] o_fall_c
);

    logic [SYNC_STAGES-1:0][N-1:0] stage_q;
    logic [N-1:0]                  prev_q;

    // Stage 0 takes the raw pins; the last stage is the clean level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], i_in};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign o_sync   = stage_q[SYNC_STAGES-1];
    assign o_rise_c = o_sync & ~prev_q;
    assign o_fall_c = ~o_sync & prev_q;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU front end: synchronised load buttons or a step sequencer capture A, B and
// the opcode from a shared bus; the cycle after each load the result is registered.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned COD_OP      = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       i_btn,
    input  logic             i_step,
    input  logic             i_mode,
    input  logic [NBITS-1:0] i_data,
    output logic [NBITS-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_valid,
    output logic             o_err,
    output logic [1:0]       o_state
);

    logic [N_CH-1:0] sync_lvl;
    logic [N_CH-1:0] rise_c;
    logic [N_CH-1:0] fall_c;

    btn_edge_sync #(
        .N           (N_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk      (clk),
        .reset    (reset),
        .i_in     ({i_mode, i_step, i_btn}),
        .o_sync   (sync_lvl),
        .o_rise_c (rise_c),
        .o_fall_c (fall_c)
    );

    logic mode_c;
    logic mode_chg_c;
    logic step_c;
    logic unused_sync;

    assign mode_c      = sync_lvl[CH_MODE];
    assign mode_chg_c  = rise_c[CH_MODE] | fall_c[CH_MODE];
    assign step_c      = rise_c[CH_STEP];
    assign unused_sync = ^{sync_lvl[CH_STEP:0], fall_c[CH_STEP:0]};

    state_t state_q;
    state_t state_d;
    logic   ld_a_c;
    logic   ld_b_c;
    logic   ld_op_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Manual mode pins the sequencer in WAIT_A; a mode change swallows a coincident step.
    always_comb begin
        state_d = state_q;
        ld_a_c  = 1'b0;
        ld_b_c  = 1'b0;
        ld_op_c = 1'b0;
        if (!mode_c) begin
            state_d = ST_WAIT_A;
            ld_a_c  = rise_c[0];
            ld_b_c  = rise_c[1];
            ld_op_c = rise_c[2];
        end else if (mode_chg_c) begin
            state_d = ST_WAIT_A;
        end else if (step_c) begin
            case (state_q)
                ST_WAIT_A: begin
                    ld_a_c  = 1'b1;
                    state_d = ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    ld_b_c  = 1'b1;
                    state_d = ST_WAIT_OP;
                end
                ST_WAIT_OP: begin
                    ld_op_c = 1'b1;
                    state_d = ST_SHOW;
                end
                default: begin
                    state_d = ST_WAIT_A;
                end
            endcase
        end
    end

    assign o_state = state_q;

    logic [NBITS-1:0]  a_q;
    logic [NBITS-1:0]  b_q;
    logic [COD_OP-1:0] op_q;
    logic              exec_q;
    logic              op_ld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            exec_q  <= 1'b0;
            op_ld_q <= 1'b0;
        end else begin
            if (ld_a_c)  a_q  <= i_data;
            if (ld_b_c)  b_q  <= i_data;
            if (ld_op_c) op_q <= i_data[COD_OP-1:0];
            exec_q  <= ld_a_c | ld_b_c | ld_op_c;
            op_ld_q <= ld_op_c;
        end
    end

    // Returns {supported, overflow, carry, result}; opcode bits above the funct
    // field must be zero, which the zero-extended case labels enforce.
    function automatic logic [NBITS+2:0] alu_eval(
        input logic [NBITS-1:0]  a,
        input logic [NBITS-1:0]  b,
        input logic [COD_OP-1:0] op
    );
        logic [NBITS:0]   wide;
        logic [NBITS-1:0] res;
        logic             c;
        logic             v;
        logic             ok;
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        ok   = 1'b1;
        case (op)
            COD_OP'(OP_ADD): begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[NBITS-1:0];
                c    = wide[NBITS];
                v    = (a[NBITS-1] == b[NBITS-1]) && (res[NBITS-1] != a[NBITS-1]);
            end
            COD_OP'(OP_SUB): begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[NBITS-1:0];
                c    = wide[NBITS];
                v    = (a[NBITS-1] != b[NBITS-1]) && (res[NBITS-1] != a[NBITS-1]);
            end
            COD_OP'(OP_AND): res = a & b;
            COD_OP'(OP_OR):  res = a | b;
            COD_OP'(OP_XOR): res = a ^ b;
            COD_OP'(OP_NOR): res = ~(a | b);
            COD_OP'(OP_SRL): begin
                if (b >= NBITS'(NBITS)) res = '0;
                else                    res = a >> b;
            end
            COD_OP'(OP_SRA): begin
                if (b >= NBITS'(NBITS)) res = {NBITS{a[NBITS-1]}};
                else                    res = $signed(a) >>> b;
            end
            default: ok = 1'b0;
        endcase
        return {ok, v, c, res};
    endfunction

    logic [NBITS+2:0] alu_c;
    logic [NBITS-1:0] alu_res_c;
    logic             alu_ok_c;

    assign alu_c     = alu_eval(a_q, b_q, op_q);
    assign alu_res_c = alu_c[NBITS-1:0];
    assign alu_ok_c  = alu_c[NBITS+2];

    // Unsupported opcodes leave result/flags untouched and raise the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (exec_q) begin
                if (alu_ok_c) begin
                    o_result   <= alu_res_c;
                    o_zero     <= (alu_res_c == '0);
                    o_carry    <= alu_c[NBITS];
                    o_overflow <= alu_c[NBITS+1];
                    o_valid    <= 1'b1;
                    if (op_ld_q) o_err <= 1'b0;
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: manual loads, flag corner cases, invalid
// opcodes, held buttons, the step sequencer and a mid-sequence reset.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] i_btn;
    logic       i_step;
    logic       i_mode;
    logic [7:0] i_data;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_carry;
    logic       o_overflow;
    logic       o_valid;
    logic       o_err;
    logic [1:0] o_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .NBITS       (8),
        .COD_OP      (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_btn      (i_btn),
        .i_step     (i_step),
        .i_mode     (i_mode),
        .i_data     (i_data),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_state    (o_state)
    );

    // Press for 3 cycles, release for 6; returns the number of o_valid cycles seen.
    task automatic drive(input logic [2:0] btn, input logic step, input logic [7:0] d,
                         output int nv);
        nv = 0;
        @(negedge clk);
        i_data = d;
        i_btn  = btn;
        i_step = step;
        repeat (3) begin @(negedge clk); if (o_valid) nv++; end
        i_btn  = 3'b000;
        i_step = 1'b0;
        repeat (6) begin @(negedge clk); if (o_valid) nv++; end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        i_btn  = 3'b000;
        i_step = 1'b0;
        i_mode = 1'b0;
        i_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL rst_result got=%h exp=00", o_result); end
        checks++; if ({o_zero, o_carry, o_overflow, o_valid, o_err} !== 5'b00000) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {o_zero, o_carry, o_overflow, o_valid, o_err}); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", o_state); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add_sub();
        int nv;
        drive(3'b001, 1'b0, 8'h04, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL op0_valid got=%0d exp=0", nv); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL op0_err got=%b exp=1", o_err); end
        drive(3'b010, 1'b0, 8'h05, nv);
        drive(3'b100, 1'b0, 8'h20, nv);
        checks++; if (nv !== 1) begin errors++; $display("FAIL add_valid got=%0d exp=1", nv); end
        checks++; if (o_result !== 8'h09) begin errors++; $display("FAIL add_result got=%h exp=09", o_result); end
        checks++; if ({o_zero, o_carry, o_overflow, o_err} !== 4'b0000) begin errors++; $display("FAIL add_flags got=%b exp=0000", {o_zero, o_carry, o_overflow, o_err}); end
        drive(3'b100, 1'b0, 8'h22, nv);
        checks++; if (o_result !== 8'hFF) begin errors++; $display("FAIL sub_result got=%h exp=ff", o_result); end
        checks++; if ({o_carry, o_overflow} !== 2'b10) begin errors++; $display("FAIL sub_flags got=%b exp=10", {o_carry, o_overflow}); end
    endtask

    task automatic test_ops();
        int nv;
        drive(3'b001, 1'b0, 8'h7F, nv);
        drive(3'b010, 1'b0, 8'h01, nv);
        drive(3'b100, 1'b0, 8'h20, nv);
        checks++; if (o_result !== 8'h80) begin errors++; $display("FAIL ovf_result got=%h exp=80", o_result); end
        checks++; if ({o_carry, o_overflow} !== 2'b01) begin errors++; $display("FAIL ovf_flags got=%b exp=01", {o_carry, o_overflow}); end
        drive(3'b001, 1'b0, 8'h09, nv);
        drive(3'b010, 1'b0, 8'h02, nv);
        drive(3'b100, 1'b0, 8'h27, nv);
        checks++; if (o_result !== 8'hF4) begin errors++; $display("FAIL nor_result got=%h exp=f4", o_result); end
        drive(3'b100, 1'b0, 8'h02, nv);
        checks++; if (o_result !== 8'h02) begin errors++; $display("FAIL srl_result got=%h exp=02", o_result); end
        drive(3'b001, 1'b0, 8'h80, nv);
        drive(3'b100, 1'b0, 8'h03, nv);
        checks++; if (o_result !== 8'hE0) begin errors++; $display("FAIL sra_result got=%h exp=e0", o_result); end
        drive(3'b010, 1'b0, 8'h09, nv);
        checks++; if (o_result !== 8'hFF) begin errors++; $display("FAIL sra_big got=%h exp=ff", o_result); end
        drive(3'b100, 1'b0, 8'h02, nv);
        checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL srl_big got=%h exp=00", o_result); end
        checks++; if ({o_zero, o_carry, o_overflow} !== 3'b100) begin errors++; $display("FAIL srl_big_flags got=%b exp=100", {o_zero, o_carry, o_overflow}); end
    endtask

    task automatic test_invalid();
        int nv;
        drive(3'b010, 1'b0, 8'h01, nv);
        checks++; if (o_result !== 8'h40) begin errors++; $display("FAIL srl1_result got=%h exp=40", o_result); end
        drive(3'b100, 1'b0, 8'h3F, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL inv_valid got=%0d exp=0", nv); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL inv_err got=%b exp=1", o_err); end
        checks++; if (o_result !== 8'h40) begin errors++; $display("FAIL inv_hold got=%h exp=40", o_result); end
        drive(3'b100, 1'b0, 8'h24, nv);
        checks++; if (nv !== 1) begin errors++; $display("FAIL and_valid got=%0d exp=1", nv); end
        checks++; if ({o_err, o_zero} !== 2'b01) begin errors++; $display("FAIL and_flags got=%b exp=01", {o_err, o_zero}); end
        checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL and_result got=%h exp=00", o_result); end
    endtask

    task automatic test_held();
        int nv    = 0;
        int first = -1;
        @(negedge clk);
        i_data = 8'h24;
        i_btn  = 3'b100;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 20) i_btn = 3'b000;
            if (o_valid) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        checks++; if (nv !== 1) begin errors++; $display("FAIL held_count got=%0d exp=1", nv); end
        checks++; if (first !== 4) begin errors++; $display("FAIL held_latency got=%0d exp=4", first); end
    endtask

    task automatic test_sequential();
        int nv;
        @(negedge clk);
        i_mode = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL seq_start got=%0d exp=0", o_state); end
        drive(3'b000, 1'b1, 8'h03, nv);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL seq_st1 got=%0d exp=1", o_state); end
        drive(3'b001, 1'b0, 8'hAA, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL seq_btn_valid got=%0d exp=0", nv); end
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL seq_btn_state got=%0d exp=1", o_state); end
        drive(3'b000, 1'b1, 8'h04, nv);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL seq_st2 got=%0d exp=2", o_state); end
        drive(3'b000, 1'b1, 8'h25, nv);
        checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL seq_st3 got=%0d exp=3", o_state); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL seq_or_valid got=%0d exp=1", nv); end
        checks++; if (o_result !== 8'h07) begin errors++; $display("FAIL seq_or_result got=%h exp=07", o_result); end
        drive(3'b111, 1'b0, 8'h00, nv);
        checks++; if ({nv[1:0], o_result} !== {2'd0, 8'h07}) begin errors++; $display("FAIL seq_btn_ignored got=%0d/%h exp=0/07", nv, o_result); end
        drive(3'b000, 1'b1, 8'h00, nv);
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL seq_wrap got=%0d exp=0", o_state); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL seq_show_valid got=%0d exp=0", nv); end
    endtask

    task automatic test_reset_mid();
        int nv;
        int cnt = 0;
        drive(3'b000, 1'b1, 8'h10, nv);
        drive(3'b000, 1'b1, 8'h20, nv);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL mid_state got=%0d exp=2", o_state); end
        checks++; if (o_result !== 8'h30) begin errors++; $display("FAIL mid_result got=%h exp=30", o_result); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({o_result, o_state} !== 10'd0) begin errors++; $display("FAIL async_rst got=%h/%0d exp=00/0", o_result, o_state); end
        checks++; if ({o_zero, o_carry, o_overflow, o_valid, o_err} !== 5'b00000) begin errors++; $display("FAIL async_rst_flags got=%b exp=00000", {o_zero, o_carry, o_overflow, o_valid, o_err}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin @(negedge clk); if (o_valid) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL post_rst_valid got=%0d exp=0", cnt); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL post_rst_state got=%0d exp=0", o_state); end
        drive(3'b000, 1'b1, 8'h01, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL new_a_valid got=%0d exp=0", nv); end
        drive(3'b000, 1'b1, 8'h02, nv);
        checks++; if (nv !== 0) begin errors++; $display("FAIL new_b_valid got=%0d exp=0", nv); end
        drive(3'b000, 1'b1, 8'h20, nv);
        checks++; if (nv !== 1) begin errors++; $display("FAIL new_op_valid got=%0d exp=1", nv); end
        checks++; if (o_result !== 8'h03) begin errors++; $display("FAIL new_result got=%h exp=03", o_result); end
        checks++; if ({o_state, o_err} !== 3'b110) begin errors++; $display("FAIL new_state_err got=%b exp=110", {o_state, o_err}); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_ops();
        test_invalid();
        test_held();
        test_sequential();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
